// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC      = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t st, nx;
  logic rdy;
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  // next-state selection; codes 13-15 fall back to FETCH
  always_comb begin
    nx = FETCH;
    case (st)
      IDLE:      nx = FETCH;
      FETCH:     nx = rdy ? DECODE : FETCH;
      DECODE:    nx = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                      (opcode == OP_R)    ? EXEC :
                      (opcode == OP_BEQ)  ? BRANCH :
                      (opcode == OP_J)    ? JUMP :
                      (opcode == OP_ADDI) ? ADDI_EX : FETCH;
      MEM_ADDR:  nx = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nx = rdy ? MEM_WB : MEM_READ;
      MEM_WRITE: nx = rdy ? FETCH : MEM_WRITE;
      EXEC:      nx = R_WB;
      ADDI_EX:   nx = ADDI_WB;
      default:   nx = FETCH;
    endcase
  end
  // state register; reset wins over every transition
  always_ff @(posedge clk)
    st <= reset ? IDLE : nx;
  // Moore output decode; only FETCH strobes and illegal_op see inputs
  always_comb begin
    pc_write      = (st == FETCH && rdy) || st == JUMP;
    pc_write_cond = st == BRANCH;
    i_or_d        = st == MEM_READ || st == MEM_WRITE;
    mem_read      = st == FETCH || st == MEM_READ;
    mem_write     = st == MEM_WRITE;
    ir_write      = st == FETCH && rdy;
    mem_to_reg    = st == MEM_WB;
    reg_dst       = st == R_WB;
    reg_write     = st == MEM_WB || st == R_WB || st == ADDI_WB;
    alu_src_a     = st == MEM_ADDR || st == EXEC || st == BRANCH || st == ADDI_EX;
    alu_src_b     = (st == FETCH) ? 2'd1 : (st == DECODE) ? 2'd3 :
                    (st == MEM_ADDR || st == ADDI_EX) ? 2'd2 : 2'd0;
    alu_op        = (st == EXEC) ? 2'd2 : (st == BRANCH) ? 2'd1 : 2'd0;
    pc_source     = (st == BRANCH) ? 2'd1 : (st == JUMP) ? 2'd2 : 2'd0;
    illegal_op    = st == DECODE && !(opcode == OP_LW || opcode == OP_SW || opcode == OP_R ||
                    opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI);
    state         = st;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM control unit for the multicycle MIPS datapath.
- Sequences every datapath select and enable, including reg_dst (the rt/rd 5-bit destination select), alu_src_a/b, pc_source, mem_to_reg and i_or_d.
- Supports R-type, lw, sw, beq, j and addi.
- Stalls on a memory ready handshake and flags illegal opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = FETCH/MEM_READ/MEM_WRITE hold until mem_ready; 0 = mem_ready ignored, treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding, for debug

Behaviour:
- State register is 4 bits. Encodings:
  - IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6
  - EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12
- Codes 13–15 are unused; if entered, next state = FETCH.
- Reset: reset sampled high at a clk edge sets state = IDLE.
  - IDLE drives every output 0, except state = 0.
  - IDLE → FETCH unconditionally.
  - Reset overrides any transition, including mid-stall or mid-instruction.
- Outputs are pure combinational decodes of state. They take no opcode or mem_ready terms, except illegal_op (see below). Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=1 and pc_write=1 only while mem_ready=1. This is the sole exception to pure state decode.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EX
  - anything else → FETCH, with illegal_op=1 for exactly this DECODE cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then → FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 → FETCH.
- JUMP: pc_write=1, pc_source=2 → FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=0 → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- Latency in clk cycles with zero wait, FETCH through last state inclusive:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each mem_ready=0 cycle in a memory state adds 1.
- Invariants:
  - reg_write and mem_write are never both 1.
  - mem_read and mem_write are never both 1.
  - reg_dst=1 only in R_WB.
- MEM_WAIT_EN=0: all three memory states advance every cycle; FETCH ir_write/pc_write are unconditionally 1.

Test Plan:
- Reset held 3 cycles mid-MEM_READ, then released → state=0 and all outputs 0 during reset; state=1 the cycle after release.
- R-type (opcode 000000), mem_ready=1 → state sequence 1,2,7,8,1; in state 8, reg_write=1, reg_dst=1, mem_to_reg=0.
- lw (100011) with mem_ready low 2 cycles in MEM_READ → sequence 1,2,3,4,4,4,5,1; in state 5, reg_write=1, mem_to_reg=1, reg_dst=0; total 7 cycles.
- sw (101011) then beq (000100) → sw state 6 shows mem_write=1, i_or_d=1, reg_write=0; beq state 9 shows pc_write_cond=1, pc_source=1, alu_op=1.
- FETCH with mem_ready=0 for 4 cycles → ir_write=0, pc_write=0, state stays 1; the 5th cycle with mem_ready=1 gives ir_write=1, pc_write=1, then state=2.
- Opcode 111111 in DECODE → illegal_op=1 for exactly 1 cycle, next state=1, no reg_write/mem_write asserted; j (000010) next → state 10 shows pc_write=1, pc_source=2.
